seq_buffer_ctrl: RTL and testbench
==================================

# seq_buffer_ctrl

Controller for the entry sequence store between the input FSM and the seven-segment display path. Accepts result words from the FSM handshake, appends them to a fixed-depth register store, latches error codes, and sequences a browse cursor that the debounced "next" button steps through. It replaces ad-hoc pointer logic in the top level with one block that has defined full, empty and wrap behaviour.

## Interface
- DEPTH, 10, number of storable entries (≥2)
- WIDTH, 32, entry width in bits
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clr  in  1  synchronous clear pulse (debounced reset button), one cycle
- wr_valid  in  1  one-cycle pulse: FSM result ready (r_o)
- wr_data  in  WIDTH  FSM result word, sampled when wr_valid=1
- wr_err  in  2  FSM error code, sampled when wr_valid=1; 0 = no error
- nxt  in  1  one-cycle pulse: advance browse cursor
- disp_data  out  WIDTH  entry at cursor; 0 when store empty
- cursor  out  CW  browse index, CW = $clog2(DEPTH+1)
- count  out  CW  number of stored entries, 0..DEPTH
- full  out  1  count == DEPTH
- err_out  out  2  last nonzero error code, sticky
- ovf  out  1  sticky: a clean write was dropped because store full

## Operation
- One clock, clk; reset is asynchronous and active-high.
- Reset values: count=0, cursor=0, err_out=0, ovf=0, all entries 0, so disp_data=0, full=0.
- Priority per edge: reset > clr > {write, nxt}.
- clr: same effect as reset, synchronous; a coincident wr_valid or nxt is ignored.
- Write, wr_valid=1 and wr_err=0: if count<DEPTH, mem[count]<=wr_data, count<=count+1. If full: nothing stored, ovf<=1.
- Write, wr_valid=1 and wr_err≠0: nothing stored, count unchanged, err_out<=wr_err (overwrites previous code). Later clean writes still accepted; err_out holds until reset/clr.
- nxt with count=0: cursor stays 0. nxt with cursor=count-1: cursor<=0 (wrap). Otherwise cursor<=cursor+1.
- Simultaneous write and nxt: both act; nxt wrap test uses count before the write.
- disp_data = mem[cursor] if cursor<count, else 0.
- Entries are never modified except by write, reset, clr.

## Timing
- All outputs registered or decoded from registers; updated values visible after the edge sampling the event, latency 1 cycle.
- wr_valid, nxt, clr are single-cycle pulses; a held level acts once per cycle (no edge detection inside).
- No back-pressure: producer never stalls; full is informational.
- Reset asserted mid-operation clears immediately, independent of clk.

## Configuration
- SEQ_CTRL_SHOW_LAST_EN defined: each accepted clean write also sets cursor<=old count (new entry's index), overriding a coincident nxt; display follows newest entry.
- Undefined: writes never move cursor; only nxt, clr, reset do.

## Structure
- Package seq_pkg: ERR_NONE=2'd0 and FSM error code constants, default DEPTH/WIDTH localparams, cursor width function.
- Sub-module seq_cursor: wrap counter with inputs step, limit(count), load, load_val; holds cursor logic so SHOW_LAST load path is isolated.
- Store is a DEPTH×WIDTH register array in the top of this block (no RAM inference; async clear required).

## Test plan
- Reset, then 3 writes 0x11,0x22,0x33 with wr_err=0 -> count=3, cursor=0, disp_data=0x11, err_out=0.
- From above, 4 nxt pulses -> disp_data 0x22,0x33,0x11,0x22 (wrap at cursor 2); nxt with count=0 -> cursor=0, disp_data=0.
- Write with wr_err=2 then clean write 0x44 -> err_out=2, count increments only for 0x44; next error wr_err=1 -> err_out=1.
- 11 clean writes with DEPTH=10 -> full=1 after 10th, 11th dropped, ovf=1, mem[9] holds 10th word.
- Write and nxt same cycle with cursor=count-1=2 -> cursor=0, count=4; with SEQ_CTRL_SHOW_LAST_EN -> cursor=3, disp_data=new word.
- clr coincident with write, then async reset pulse between edges -> count=0, err_out=0, ovf=0, disp_data=0 immediately on reset.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants for the entry sequence store: FSM error codes, default
// geometry and the cursor/count width helper.
package seq_pkg;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_CODE_1 = 2'd1;
    localparam logic [1:0] ERR_CODE_2 = 2'd2;
    localparam logic [1:0] ERR_CODE_3 = 2'd3;

    localparam int DEPTH_DEF = 10;
    localparam int WIDTH_DEF = 32;

    // Width able to hold 0..depth inclusive, so count can report "full".
    function automatic int cursor_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/seq_cursor.sv
// Browse cursor for the sequence store: wrapping step over the stored entries,
// plus a load path used when the display tracks the newest entry.
module seq_cursor #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          step,
    input  logic [CW-1:0] limit,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cursor
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cursor <= '0;
        end else if (clr) begin
            cursor <= '0;
        end else if (load) begin
            cursor <= load_val;
        end else if (step) begin
            // limit is the entry count before any coincident write.
            if (limit == '0 || cursor >= limit - CW'(1)) begin
                cursor <= '0;
            end else begin
                cursor <= cursor + CW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_buffer_ctrl.sv
// Entry sequence store controller: append-only register store, sticky error
// and overflow flags, browse cursor. Optional macro SEQ_CTRL_SHOW_LAST_EN makes
// each accepted write move the cursor to the new entry.
module seq_buffer_ctrl
    import seq_pkg::*;
#(
    parameter int  DEPTH = DEPTH_DEF,
    parameter int  WIDTH = WIDTH_DEF,
    localparam int CW    = cursor_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [1:0]       wr_err,
    input  logic             nxt,
    output logic [WIDTH-1:0] disp_data,
    output logic [CW-1:0]    cursor,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic [1:0]       err_out,
    output logic             ovf
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_clean;
    logic             accept;
    logic             load;

    assign full     = (count == CW'(DEPTH));
    assign wr_clean = wr_valid && (wr_err == ERR_NONE);
    assign accept   = wr_clean && !full && !clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            err_out <= ERR_NONE;
            ovf     <= 1'b0;
        end else if (clr) begin
            count   <= '0;
            err_out <= ERR_NONE;
            ovf     <= 1'b0;
        end else begin
            if (accept) count <= count + CW'(1);
            if (wr_clean && full) ovf <= 1'b1;
            if (wr_valid && wr_err != ERR_NONE) err_out <= wr_err;
        end
    end

    // NOTE: the store is cleared by reset and clr, so it must stay flops;
    // a RAM macro could not be asynchronously cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (accept && count == CW'(i)) mem[i] <= wr_data;
            end
        end
    end

    // NOTE: default assignment first so no path through the loop infers a latch.
    always_comb begin
        disp_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cursor == CW'(i) && cursor < count) disp_data = mem[i];
        end
    end

`ifdef SEQ_CTRL_SHOW_LAST_EN
    assign load = accept;
`else
    assign load = 1'b0;
`endif

    seq_cursor #(
        .CW(CW)
    ) u_cursor (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .step     (nxt),
        .limit    (count),
        .load     (load),
        .load_val (count),
        .cursor   (cursor)
    );

endmodule

// File: tb/tb_seq_buffer_ctrl.sv
// Scoreboard bench for seq_buffer_ctrl: directed scenarios then random traffic,
// checked against a queue-based model of the entry store.
module tb_seq_buffer_ctrl;
    import seq_pkg::*;

    localparam int DEPTH = 10;
    localparam int WIDTH = 32;
    localparam int CW    = cursor_width(DEPTH);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             clr = 1'b0;
    logic             wr_valid = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [1:0]       wr_err = 2'd0;
    logic             nxt = 1'b0;
    logic [WIDTH-1:0] disp_data;
    logic [CW-1:0]    cursor;
    logic [CW-1:0]    count;
    logic             full;
    logic [1:0]       err_out;
    logic             ovf;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          count;
        int          cursor;
        logic [31:0] disp;
        bit          full;
        logic [1:0]  err;
        bit          ovf;
    } snap_t;

    snap_t exp_q[$];

    // Reference model: stored words as a growing queue.
    logic [31:0] m_store[$];
    int          m_cur;
    logic [1:0]  m_err;
    bit          m_ovf;

    seq_buffer_ctrl #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_err    (wr_err),
        .nxt       (nxt),
        .disp_data (disp_data),
        .cursor    (cursor),
        .count     (count),
        .full      (full),
        .err_out   (err_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.count  = m_store.size();
        s.cursor = m_cur;
        s.disp   = (m_cur < m_store.size()) ? m_store[m_cur] : 32'd0;
        s.full   = (m_store.size() == DEPTH);
        s.err    = m_err;
        s.ovf    = m_ovf;
        return s;
    endfunction

    task automatic model_reset();
        m_store.delete();
        m_cur = 0;
        m_err = 2'd0;
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input bit c, input bit w, input logic [31:0] d,
                              input logic [1:0] e, input bit n);
        int old_n;
        bit ok;
        if (c) begin
            model_reset();
            return;
        end
        old_n = m_store.size();
        ok = w && e == 2'd0 && old_n < DEPTH;
        if (w && e != 2'd0) m_err = e;
        if (w && e == 2'd0 && old_n == DEPTH) m_ovf = 1'b1;
        if (n) m_cur = (old_n == 0) ? 0 : (m_cur + 1) % old_n;
        if (ok) begin
            m_store.push_back(d);
`ifdef SEQ_CTRL_SHOW_LAST_EN
            m_cur = old_n;
`endif
        end
    endtask

    // One clock cycle of stimulus; the expected post-edge state goes to the scoreboard.
    task automatic cyc(input bit c, input bit w, input logic [31:0] d,
                       input logic [1:0] e, input bit n);
        clr      = c;
        wr_valid = w;
        wr_data  = d;
        wr_err   = e;
        nxt      = n;
        @(posedge clk);
        model_step(c, w, d, e, n);
        exp_q.push_back(model_snap());
        @(negedge clk);
        clr      = 1'b0;
        wr_valid = 1'b0;
        nxt      = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges; effect must be immediate.
    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_cursor", 32'(cursor), 32'd0);
        check("async_disp", disp_data, 32'd0);
        check("async_err", 32'(err_out), 32'd0);
        check("async_ovf", 32'(ovf), 32'd0);
        check("async_full", 32'(full), 32'd0);
        model_reset();
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: compares every registered output once per cycle against the scoreboard.
    initial begin
        snap_t s;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                check("count", 32'(count), 32'(s.count));
                check("cursor", 32'(cursor), 32'(s.cursor));
                check("disp_data", disp_data, s.disp);
                check("full", 32'(full), 32'(s.full));
                check("err_out", 32'(err_out), 32'(s.err));
                check("ovf", 32'(ovf), 32'(s.ovf));
            end
        end
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  e;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_disp", disp_data, 32'd0);
        check("rst_full", 32'(full), 32'd0);
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0);

        // Three clean writes, then browse with wrap.
        cyc(0, 1, 32'h11, 0, 0);
        cyc(0, 1, 32'h22, 0, 0);
        cyc(0, 1, 32'h33, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 1);

        // nxt on an empty store.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);

        // Error codes interleaved with clean writes.
        cyc(0, 1, 32'hdead, 2'd2, 0);
        cyc(0, 1, 32'h44, 0, 0);
        cyc(0, 1, 32'hbeef, 2'd1, 0);
        cyc(0, 0, 0, 0, 1);

        // Fill past capacity, then browse to the last slot.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) cyc(0, 1, 32'h100 + 32'(i), 0, 0);
        repeat (9) cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 32'h777, 0, 1);

        // Write and nxt together with cursor at count-1.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'h11, 0, 0);
        cyc(0, 1, 32'h22, 0, 0);
        cyc(0, 1, 32'h33, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 32'h99, 0, 1);

        // clr beats a coincident write and nxt; then async reset mid-cycle.
        cyc(1, 1, 32'h55, 0, 1);
        cyc(0, 1, 32'h66, 0, 0);
        cyc(0, 1, 32'h67, 2'd3, 0);
        async_reset_pulse();
        cyc(0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            d = $urandom;
            e = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            if ($urandom_range(0, 63) == 0) begin
                async_reset_pulse();
            end else begin
                cyc($urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1, d, e,
                    $urandom_range(0, 4) < 2);
            end
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
